dither_shader: RTL and testbench
================================

// Module: dither_shader
// PURPOSE
//  Parametrised line shader: streams one line of packed RGB fixed-point samples from the UV line RAM,
//  applies ordered (Bayer) dithering with saturation, and writes quantised pixels to the pixel line RAM.
//  Sits between the rasteriser's UV buffer and the scan-out pixel buffer.
//  Adds configurable widths, matrix size and RAM read latency, an explicit run/drain FSM, exact-length writes and a busy flag.
// PARAMETERS
//  LINE_W     640  pixels per line; written addresses are 0..LINE_W-1
//  X_W        10   x address width; requires 2^X_W >= LINE_W
//  RG_IN_W    12   R and G input width in uv_data
//  B_IN_W     8    B input width in uv_data
//  R_OUT_W    3    R output width
//  G_OUT_W    3    G output width
//  B_OUT_W    2    B output width
//  BAYER_LOG2 2    dither matrix is 2^BAYER_LOG2 square (1 gives 2x2, 2 gives 4x4)
//  RD_LAT     1    UV RAM read latency in cycles (>=1)
// PORTS
//  clk100     in   1                      system clock
//  rst        in   1                      synchronous, active-high reset
//  uv_addr    out  X_W+1                  {buf, x} read address
//  uv_data    in   2*RG_IN_W+B_IN_W       {R,G,B}, MSB first; valid RD_LAT cycles after uv_addr
//  px_addr    out  X_W+1                  {buf, x} write address
//  px_data    out  R_OUT_W+G_OUT_W+B_OUT_W {R,G,B} quantised pixel
//  px_we      out  1                      write strobe, one pixel per cycle
//  next_line  in   1                      pulse: start the next line
//  next_frame in   1                      pulse: restart at line 0
//  busy       out  1                      high while RUN or DRAIN
// BEHAVIOUR
//  - Reset: uv_addr=0, px_addr=0, px_data=0, px_we=0, busy=0.
//    Internal state after reset: state=IDLE, line_cnt=0, buf=0.
//  - FSM states:
//    IDLE: waits for next_line.
//    RUN: issues reads.
//    DRAIN: waits until the RD_LAT+1 read pipeline is empty, then returns to IDLE.
//  - Starting a line: next_line sampled at cycle c (no next_frame) increments line_cnt and toggles buf.
//    It clears x; RUN begins and uv_addr={buf,0} is valid at c+1.
//  - RUN: uv_addr x increments each cycle for exactly LINE_W cycles (0..LINE_W-1), then the FSM enters DRAIN.
//  - Pipeline: x and a valid bit are carried through an RD_LAT-deep shift register.
//    The pixel for x is registered one cycle after its data returns.
//    Read x issued at cycle k gives px_we=1 with px_addr={buf,x} at cycle k+RD_LAT+1.
//    px_we is high for exactly LINE_W consecutive cycles per line; no writes occur at x>=LINE_W.
//  - Dither index t (2*BAYER_LOG2 bits) is bit-interleaved, MSB first: pairs (x[i]^y[i], y[i]) for i=0..BAYER_LOG2-1.
//    Here y=line_cnt. For 4x4 the order is {x0^y0, y0, x1^y1, y1}.
//  - Per channel of input width IN and output width OUT:
//    offset = (t << (IN-OUT)) >> (2*BAYER_LOG2);
//    d = c + offset, computed IN+1 bits wide;
//    result = d[IN] ? all-ones : d[IN-1 -: OUT]. Arithmetic is unsigned.
//  - next_frame takes priority over next_line.
//    It clears line_cnt=0 and buf=0, and starts RUN with x=0 on the next cycle.
//    It flushes the pipeline: px_we=0 from the next cycle until new data arrives.
//  - next_line or next_frame during RUN/DRAIN aborts the current line:
//    the pipeline is flushed, px_we drops the next cycle, and the new line starts as above.
//  - rst asserted mid-line: all outputs take reset values on the next edge; the in-flight line is discarded.
//  - line_cnt wraps modulo 2^BAYER_LOG2; only its low bits are stored.
// CONFIGURATION
//  - DITHER_TEMPORAL_EN defined: a BAYER_LOG2-bit frame_cnt increments on each next_frame (wraps).
//    The index then uses y = line_cnt + frame_cnt (mod 2^BAYER_LOG2), so the pattern rolls one row per frame.
//    rst clears frame_cnt.
//  - DITHER_TEMPORAL_EN undefined: no frame_cnt, y = line_cnt; the pattern is static across frames.
// STRUCTURE
//  - Package dither_pkg: FSM state constants (IDLE, RUN, DRAIN) and the bayer_index function (x, y, log2).
//  - Sub-module dither_channel, instanced three times (R, G, B).
//    Parameters IN_W, OUT_W, BAYER_LOG2. Combinational add of the scaled offset and saturate to OUT_W.
// TESTING
//  - rst for 3 cycles, then idle: px_we=0 and busy=0 on every cycle, with no spurious writes.
//  - Defaults, single line, uv_data constant 0x000_000_00:
//    exactly 640 writes, px_addr {1,0..639}, px_data matching the Bayer offset, last write at addr 639.
//  - uv_data R=G=0xFFF, B=0xFF: every px_data=8'hFF (saturation), with no wrap to 0.
//  - R=0x100, line 0, x=0..3:
//    t=0,8,2,10 → R=0x100,0x200,0x140,0x240 → R_out=0,1,0,1.
//  - next_line at x=300 of a line: px_we low the next cycle, then a new line at buf toggled with x=0, and 640 writes follow.
//  - Simultaneous next_frame and next_line: line_cnt=0, buf=0, and uv_addr={0,0} on the next cycle.
//    With DITHER_TEMPORAL_EN, the row pattern of frame 1 equals frame 0 shifted by one row.

Source files
------------

// File: rtl/dither_pkg.sv
// Shared definitions for the Bayer line shader: FSM states and the interleaved dither index.
package dither_pkg;

    localparam int MAX_BAYER_LOG2 = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Index bits are emitted MSB first as (x[i]^y[i], y[i]) for i = 0 .. log2-1.
    function automatic logic [2*MAX_BAYER_LOG2-1:0] bayer_index(
        input logic [MAX_BAYER_LOG2-1:0] x,
        input logic [MAX_BAYER_LOG2-1:0] y,
        input int                        log2
    );
        logic [2*MAX_BAYER_LOG2-1:0] t;
        t = '0;
        for (int i = 0; i < MAX_BAYER_LOG2; i++) begin
            if (i < log2) begin
                t = {t[2*MAX_BAYER_LOG2-3:0], x[i] ^ y[i], y[i]};
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/dither_channel.sv
// One colour channel: adds the scaled Bayer threshold to the sample and saturates to OUT_W bits.
module dither_channel #(
    parameter int IN_W       = 12,
    parameter int OUT_W      = 3,
    parameter int BAYER_LOG2 = 2
) (
    input  logic [IN_W-1:0]         c,
    input  logic [2*BAYER_LOG2-1:0] t,
    output logic [OUT_W-1:0]        q
);

    localparam int TW = 2 * BAYER_LOG2;
    localparam int SH = IN_W - OUT_W;
    localparam int WW = TW + SH + 1;

    logic [WW-1:0]   t_scaled;
    logic [IN_W:0]   offset;
    logic [IN_W:0]   d;

    always_comb begin
        t_scaled = WW'(t) << SH;
        offset   = (IN_W + 1)'(t_scaled >> TW);
        d        = {1'b0, c} + offset;
        // Carry out of the add means the dithered value overflowed: clamp instead of wrapping.
        q        = d[IN_W] ? {OUT_W{1'b1}} : d[IN_W-1 -: OUT_W];
    end

endmodule

// File: rtl/dither_shader.sv
// Line shader: reads a line of RGB samples, Bayer-dithers them and writes quantised pixels.
// Define DITHER_TEMPORAL_EN to roll the dither pattern by one row per frame.
module dither_shader
    import dither_pkg::*;
#(
    parameter int LINE_W     = 640,
    parameter int X_W        = 10,
    parameter int RG_IN_W    = 12,
    parameter int B_IN_W     = 8,
    parameter int R_OUT_W    = 3,
    parameter int G_OUT_W    = 3,
    parameter int B_OUT_W    = 2,
    parameter int BAYER_LOG2 = 2,
    parameter int RD_LAT     = 1
) (
    input  logic                                  clk100,
    input  logic                                  rst,
    output logic [X_W:0]                          uv_addr,
    input  logic [2*RG_IN_W+B_IN_W-1:0]           uv_data,
    output logic [X_W:0]                          px_addr,
    output logic [R_OUT_W+G_OUT_W+B_OUT_W-1:0]    px_data,
    output logic                                  px_we,
    input  logic                                  next_line,
    input  logic                                  next_frame,
    output logic                                  busy
);

    localparam int PX_W = R_OUT_W + G_OUT_W + B_OUT_W;
    localparam logic [X_W-1:0] X_LAST = X_W'(LINE_W - 1);

    state_t                  state_q, state_d;
    logic [X_W-1:0]          x_q, x_d;
    logic                    buf_q, buf_d;
    logic [BAYER_LOG2-1:0]   line_cnt_q, line_cnt_d;
    logic [BAYER_LOG2-1:0]   y;

    logic [RD_LAT-1:0]       pipe_v_q, pipe_v_d;
    logic [X_W-1:0]          pipe_x_q [RD_LAT];
    logic [X_W-1:0]          pipe_x_d [RD_LAT];

    logic [X_W:0]            px_addr_q, px_addr_d;
    logic [PX_W-1:0]         px_data_q, px_data_d;
    logic                    px_we_q, px_we_d;

    logic                    start;
    logic                    issue;
    logic                    out_valid;

    logic [2*MAX_BAYER_LOG2-1:0] t_full;
    logic [2*BAYER_LOG2-1:0]     t;
    logic                        unused_t;
    logic [R_OUT_W-1:0]          r_out;
    logic [G_OUT_W-1:0]          g_out;
    logic [B_OUT_W-1:0]          b_out;

    assign start = next_line | next_frame;
    assign issue = (state_q == RUN);

`ifdef DITHER_TEMPORAL_EN
    logic [BAYER_LOG2-1:0] frame_cnt_q, frame_cnt_d;

    assign frame_cnt_d = frame_cnt_q + BAYER_LOG2'(next_frame);
    assign y           = line_cnt_q + frame_cnt_q;

    always_ff @(posedge clk100) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    assign y = line_cnt_q;
`endif

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        buf_d      = buf_q;
        line_cnt_d = line_cnt_q;
        if (next_frame) begin
            state_d    = RUN;
            x_d        = '0;
            buf_d      = 1'b0;
            line_cnt_d = '0;
        end else if (next_line) begin
            state_d    = RUN;
            x_d        = '0;
            buf_d      = ~buf_q;
            line_cnt_d = line_cnt_q + 1'b1;
        end else begin
            case (state_q)
                IDLE: ;
                RUN: begin
                    if (x_q == X_LAST) begin
                        state_d = DRAIN;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // Stay busy until the last pixel has left the output register.
                    if ((pipe_v_q == '0) && !px_we_q) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Read pipeline: a new line start discards every in-flight read.
    assign pipe_v_d[0] = issue & ~start;
    assign pipe_x_d[0] = x_q;

    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
            assign pipe_v_d[gi] = pipe_v_q[gi-1] & ~start;
            assign pipe_x_d[gi] = pipe_x_q[gi-1];
        end
    endgenerate

    assign out_valid = pipe_v_q[RD_LAT-1] & ~start;

    always_comb begin
        t_full = bayer_index(MAX_BAYER_LOG2'(pipe_x_q[RD_LAT-1]), MAX_BAYER_LOG2'(y), BAYER_LOG2);
        t      = t_full[2*BAYER_LOG2-1:0];
    end
    assign unused_t = ^t_full;

    dither_channel #(.IN_W(RG_IN_W), .OUT_W(R_OUT_W), .BAYER_LOG2(BAYER_LOG2)) u_chan_r (
        .c (uv_data[2*RG_IN_W+B_IN_W-1 -: RG_IN_W]),
        .t (t),
        .q (r_out)
    );

    dither_channel #(.IN_W(RG_IN_W), .OUT_W(G_OUT_W), .BAYER_LOG2(BAYER_LOG2)) u_chan_g (
        .c (uv_data[RG_IN_W+B_IN_W-1 -: RG_IN_W]),
        .t (t),
        .q (g_out)
    );

    dither_channel #(.IN_W(B_IN_W), .OUT_W(B_OUT_W), .BAYER_LOG2(BAYER_LOG2)) u_chan_b (
        .c (uv_data[B_IN_W-1:0]),
        .t (t),
        .q (b_out)
    );

    always_comb begin
        px_we_d   = out_valid;
        px_addr_d = px_addr_q;
        px_data_d = px_data_q;
        if (out_valid) begin
            px_addr_d = {buf_q, pipe_x_q[RD_LAT-1]};
            px_data_d = {r_out, g_out, b_out};
        end
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            buf_q      <= 1'b0;
            line_cnt_q <= '0;
            pipe_v_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_x_q[i] <= '0;
            end
            px_addr_q  <= '0;
            px_data_q  <= '0;
            px_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            buf_q      <= buf_d;
            line_cnt_q <= line_cnt_d;
            pipe_v_q   <= pipe_v_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_x_q[i] <= pipe_x_d[i];
            end
            px_addr_q  <= px_addr_d;
            px_data_q  <= px_data_d;
            px_we_q    <= px_we_d;
        end
    end

    assign uv_addr = {buf_q, x_q};
    assign px_addr = px_addr_q;
    assign px_data = px_data_q;
    assign px_we   = px_we_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_dither_shader.sv
// Randomised bench for dither_shader against a line-level reference model of the dither rules.
module tb_dither_shader;

    localparam int LINE_W = 640;
    localparam int X_W    = 10;
    localparam int BL     = 2;
    localparam int RD_LAT = 1;
    localparam int NB     = 1 << BL;

    logic        clk100 = 1'b0;
    logic        rst;
    logic [10:0] uv_addr;
    logic [31:0] uv_data;
    logic [10:0] px_addr;
    logic [7:0]  px_data;
    logic        px_we;
    logic        next_line;
    logic        next_frame;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [2048];
    logic [18:0] exp_q [$];
    logic [7:0]  cap [1024];
    logic [10:0] last_addr;
    int          line_writes;
    int          m_line, m_buf, m_frame;

    dither_shader #(
        .LINE_W(LINE_W), .X_W(X_W), .RG_IN_W(12), .B_IN_W(8),
        .R_OUT_W(3), .G_OUT_W(3), .B_OUT_W(2), .BAYER_LOG2(BL), .RD_LAT(RD_LAT)
    ) dut (
        .clk100     (clk100),
        .rst        (rst),
        .uv_addr    (uv_addr),
        .uv_data    (uv_data),
        .px_addr    (px_addr),
        .px_data    (px_data),
        .px_we      (px_we),
        .next_line  (next_line),
        .next_frame (next_frame),
        .busy       (busy)
    );

    always #5 clk100 = ~clk100;

    // UV line RAM with a single registered read stage
    always @(posedge clk100) uv_data <= mem[uv_addr];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int quant(input int c, input int in_w, input int out_w, input int t);
        int off, d;
        off = (t * (1 << (in_w - out_w))) / (1 << (2 * BL));
        d   = c + off;
        if (d >= (1 << in_w)) return (1 << out_w) - 1;
        return d / (1 << (in_w - out_w));
    endfunction

    function automatic logic [7:0] exp_px(input logic [31:0] w, input int x, input int y);
        int t, xb, yb, r, g, b;
        t = 0;
        for (int i = 0; i < BL; i++) begin
            xb = (x >> i) & 1;
            yb = (y >> i) & 1;
            t  = t + ((xb ^ yb) * 2 + yb) * (1 << (2 * (BL - 1 - i)));
        end
        r = quant(int'(w[31:20]), 12, 3, t);
        g = quant(int'(w[19:8]), 12, 3, t);
        b = quant(int'(w[7:0]), 8, 2, t);
        return 8'(r * 32 + g * 4 + b);
    endfunction

    always @(negedge clk100) begin
        if (!rst && px_we) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", 64'(px_we), 64'd0);
            end else begin
                check("px_write", 64'({px_addr, px_data}), 64'(exp_q.pop_front()));
                line_writes++;
                last_addr = px_addr;
                cap[px_addr[9:0]] = px_data;
            end
        end
    end

    task automatic fill(input int mode);
        for (int i = 0; i < 2048; i++) begin
            case (mode)
                0:       mem[i] = 32'h0;
                1:       mem[i] = 32'hFFFF_FFFF;
                2:       mem[i] = {12'h100, 12'h000, 8'h00};
                default: mem[i] = $urandom;
            endcase
        end
    endtask

    // Called at a falling edge; the model steps and the pulse is sampled at the next rising edge.
    task automatic start_line(input bit nf, input bit nl);
        int y, addr;
        #1;
        if (nf) begin
            m_line = 0; m_buf = 0; m_frame = (m_frame + 1) % NB;
        end else if (nl) begin
            m_line = (m_line + 1) % NB; m_buf = 1 - m_buf;
        end
`ifdef DITHER_TEMPORAL_EN
        y = (m_line + m_frame) % NB;
`else
        y = m_line;
`endif
        exp_q.delete();
        for (int x = 0; x < LINE_W; x++) begin
            addr = m_buf * 1024 + x;
            exp_q.push_back({11'(addr), exp_px(mem[addr], x, y)});
        end
        line_writes = 0;
        next_frame = nf;
        next_line  = nl;
        @(posedge clk100);
        #1;
        next_frame = 1'b0;
        next_line  = 1'b0;
        @(negedge clk100);
        check("start_uv_addr", 64'(uv_addr), 64'(m_buf * 1024));
        check("start_we_low", 64'(px_we), 64'd0);
        check("start_busy", 64'(busy), 64'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk100);
            n++;
        end
        check("line_timeout", 64'(exp_q.size()), 64'd0);
        repeat (RD_LAT + 4) @(negedge clk100);
        check("done_busy", 64'(busy), 64'd0);
        check("done_we", 64'(px_we), 64'd0);
        check("line_writes", 64'(line_writes), 64'(LINE_W));
        $display("line buf=%0d line=%0d frame=%0d writes=%0d last_addr=0x%0h",
                 m_buf, m_line, m_frame, line_writes, last_addr);
    endtask

    initial begin
        logic [2:0] r_exp [4];
        int n;
        bit nf;
        r_exp = '{3'd0, 3'd1, 3'd0, 3'd1};
        m_line = 0; m_buf = 0; m_frame = 0;
        line_writes = 0;
        last_addr = '0;
        next_line = 1'b0;
        next_frame = 1'b0;
        fill(0);
        rst = 1'b1;
        repeat (3) @(posedge clk100);
        @(negedge clk100);
        check("rst_uv_addr", 64'(uv_addr), 64'd0);
        check("rst_px_addr", 64'(px_addr), 64'd0);
        check("rst_px_data", 64'(px_data), 64'd0);
        check("rst_px_we", 64'(px_we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk100);
            check("idle_we", 64'(px_we), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
        end

        // zero samples: pure Bayer offset pattern, buf toggles to 1
        fill(0);
        start_line(1'b0, 1'b1);
        wait_done();
        check("last_addr", 64'(last_addr), 64'(1024 + LINE_W - 1));

        // full-scale samples saturate rather than wrapping
        fill(1);
        start_line(1'b0, 1'b1);
        wait_done();
        check("sat_first", 64'(cap[0]), 64'hFF);
        check("sat_last", 64'(cap[LINE_W-1]), 64'hFF);

        // R=0x100 on line 0 of a new frame
        fill(2);
        start_line(1'b1, 1'b0);
        wait_done();
        for (int x = 0; x < 4; x++) check("r100_pattern", 64'(cap[x][7:5]), 64'(r_exp[x]));

        // abort a line at x=300 with next_line
        fill(3);
        start_line(1'b0, 1'b1);
        n = 0;
        while (uv_addr[9:0] != 10'd300 && n < 1000) begin
            @(negedge clk100);
            n++;
        end
        check("abort_reach", 64'(uv_addr[9:0]), 64'd300);
        start_line(1'b0, 1'b1);
        wait_done();

        // simultaneous next_frame and next_line mid-line
        fill(3);
        start_line(1'b0, 1'b1);
        repeat (100) @(negedge clk100);
        start_line(1'b1, 1'b1);
        wait_done();

        // random lines and frames
        for (int k = 0; k < 6; k++) begin
            fill(3);
            nf = ($urandom_range(0, 3) == 0);
            start_line(nf, !nf);
            wait_done();
        end

        // reset in the middle of a line
        fill(3);
        start_line(1'b0, 1'b1);
        repeat (50) @(negedge clk100);
        #1;
        rst = 1'b1;
        @(negedge clk100);
        check("midrst_uv_addr", 64'(uv_addr), 64'd0);
        check("midrst_px_we", 64'(px_we), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_px_data", 64'(px_data), 64'd0);
        exp_q.delete();
        m_line = 0; m_buf = 0; m_frame = 0;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk100);
            check("post_rst_we", 64'(px_we), 64'd0);
        end
        start_line(1'b0, 1'b1);
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
